// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_pkg
//  Description : Shared types and default timing constants for the LED blink
//                driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_blink_pkg;

    // Sequencer states; the encoding is fixed here so every user agrees on it
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } led_state_t;

    // 20 ms on / 20 ms off at a 50 MHz system clock
    localparam int unsigned DEF_ON_CYC  = 1_000_000;
    localparam int unsigned DEF_OFF_CYC = 1_000_000;

endpackage : led_blink_pkg
`default_nettype wire

// File: rtl/led_blink_driver.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_driver
//  Description : Turns a one-cycle request carrying a blink count into a
//                human-visible on/off LED sequence, with a one-deep pending
//                slot (last request wins) for requests made while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_driver
    import led_blink_pkg::*;
#(
    parameter int unsigned ON_CYC  = DEF_ON_CYC,
    parameter int unsigned OFF_CYC = DEF_OFF_CYC,
    parameter int          CNT_W   = 21,
    parameter int          N_W     = 4
) (
    input  logic           system_clk,
    input  logic           system_rst,
    input  logic           req,
    input  logic [N_W-1:0] req_n,
    output logic           led_out,
    output logic           busy,
    output logic           done
);

    // Terminal counter values for each phase
    localparam logic [CNT_W-1:0] C_ON_LAST  = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] C_OFF_LAST = CNT_W'(OFF_CYC - 1);

    led_state_t     r_state;
    led_state_t     w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic [N_W-1:0] r_left;
    logic [N_W-1:0] w_left_n;
    logic           r_pend_v;
    logic           w_pend_v_n;
    logic [N_W-1:0] r_pend_n;
    logic [N_W-1:0] w_pend_n_n;
    logic           w_done_n;
    logic           w_req_ok;

    // A zero blink count is never a real request
    assign w_req_ok = req && (req_n != '0);

    // Next-state, counter, pending slot and completion decode
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt + CNT_W'(1);
        w_left_n   = r_left;
        w_pend_v_n = r_pend_v;
        w_pend_n_n = r_pend_n;
        w_done_n   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_n = '0;
                if (w_req_ok) begin
                    w_state_n = ST_ON;
                    w_left_n  = req_n;
                end
            end

            ST_ON: begin
                if (w_req_ok) begin
                    w_pend_v_n = 1'b1;
                    w_pend_n_n = req_n;
                end
                if (r_cnt == C_ON_LAST) begin
                    w_cnt_n   = '0;
                    w_state_n = ST_OFF;
                end
            end

            ST_OFF: begin
                if (w_req_ok) begin
                    w_pend_v_n = 1'b1;
                    w_pend_n_n = req_n;
                end
                if (r_cnt == C_OFF_LAST) begin
                    w_cnt_n = '0;
                    if (r_left > N_W'(1)) begin
                        w_left_n  = r_left - N_W'(1);
                        w_state_n = ST_ON;
                    end else begin
                        // Last blink finished: a same-cycle request beats the
                        // pending one, otherwise the pending one follows on
                        w_done_n = 1'b1;
                        if (w_req_ok) begin
                            w_left_n   = req_n;
                            w_state_n  = ST_ON;
                            w_pend_v_n = 1'b0;
                            w_pend_n_n = '0;
                        end else if (r_pend_v) begin
                            w_left_n   = r_pend_n;
                            w_state_n  = ST_ON;
                            w_pend_v_n = 1'b0;
                            w_pend_n_n = '0;
                        end else begin
                            w_left_n  = '0;
                            w_state_n = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                w_state_n = ST_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    // State register; outputs are registered from the next state so they
    // line up with the state they describe
    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_left   <= '0;
            r_pend_v <= 1'b0;
            r_pend_n <= '0;
            led_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_left   <= w_left_n;
            r_pend_v <= w_pend_v_n;
            r_pend_n <= w_pend_n_n;
            led_out  <= (w_state_n == ST_ON);
            busy     <= (w_state_n != ST_IDLE);
            done     <= w_done_n;
        end
    end

endmodule : led_blink_driver
`default_nettype wire
